// File: rtl/fp_pkg.sv
// Shared constants and types for the 8-bit float <-> 12-bit linear FP datapath.
// Used by both the linear-to-float encoder and the float-to-linear decoder.
package fp_pkg;

  localparam int FP_EXP_W  = 3;
  localparam int FP_MANT_W = 4;
  localparam int FP_W      = 8;
  localparam int DEC_W     = 12;
  localparam int MAG_W     = 11;

  // Field positions inside the 8-bit code {sign, exp[2:0], mant[3:0]}
  localparam int FP_SIGN_BIT = 7;
  localparam int FP_EXP_MSB  = 6;
  localparam int FP_EXP_LSB  = 4;
  localparam int FP_MANT_MSB = 3;
  localparam int FP_MANT_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/float_to_linear.sv
// Iterative decoder: 8-bit float code {sign, exp, mant} -> 12-bit two's-complement
// value (mant << exp, sign applied last). One conversion in flight at a time.
module float_to_linear
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_fp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEC_W-1:0] out_dec,
  output logic             busy
);

  state_e               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [FP_EXP_W-1:0]  cnt_q, cnt_d;
  logic [MAG_W-1:0]     mag_q, mag_d;
  logic                 out_valid_q, out_valid_d;
  logic [DEC_W-1:0]     out_dec_q, out_dec_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      mag_q       <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    out_valid_d = out_valid_q;
    out_dec_d   = out_dec_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_fp[FP_SIGN_BIT];
          cnt_d   = in_fp[FP_EXP_MSB:FP_EXP_LSB];
          mag_d   = {{(MAG_W-FP_MANT_W){1'b0}}, in_fp[FP_MANT_MSB:FP_MANT_LSB]};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        // Max magnitude 0x780 fits in 11 bits, so the 12-bit negate never overflows
        out_dec_d   = sign_q ? (~{1'b0, mag_q} + DEC_W'(1)) : {1'b0, mag_q};
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_dec   = out_dec_q;

endmodule

// File: tb/tb_float_to_linear.sv
// Self-checking bench for float_to_linear: directed codes with hand-computed
// results, plus an arithmetic reference model checked every cycle.
module tb_float_to_linear;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_fp;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_dec;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] model_q = '0;

  float_to_linear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_dec(input logic [7:0] code);
    int m;
    m = int'(code[3:0]) * (1 << code[6:4]);
    if (code[7]) m = -m;
    return 12'(m);
  endfunction

  function automatic int ref_lat(input logic [7:0] code);
    return int'(code[6:4]) + 2;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: latch expected result on each accepted code
  always @(posedge clk)
    if (!rst && in_valid && in_ready) model_q <= ref_dec(in_fp);

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_vs_busy", int'(in_ready), int'(!busy));
      if (out_valid) check("model_out_dec", int'(out_dec), int'(model_q));
    end
  end

  task automatic accept(input logic [7:0] code);
    @(negedge clk);
    in_fp    = code;
    in_valid = 1'b1;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until out_valid rises.
  task automatic wait_result(input logic [7:0] code, input logic [11:0] lit, input string name);
    int edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1 edges++;
    end
    check({name, "_latency"}, edges, ref_lat(code));
    check({name, "_value"}, int'(out_dec), int'(lit));
    if (out_ready) begin
      @(posedge clk);
      #1 check({name, "_one_cycle"}, int'(out_valid), 0);
    end
  endtask

  task automatic convert(input logic [7:0] code, input logic [11:0] lit, input string name);
    out_ready = 1'b1;
    accept(code);
    wait_result(code, lit, name);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fp = '0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_dec", int'(out_dec), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    convert(8'h7F, 12'h780, "max_pos");
    convert(8'hAB, 12'hFD4, "neg_44");
    convert(8'h05, 12'h005, "pos_5");
    convert(8'h80, 12'h000, "neg_zero");
    convert(8'hF0, 12'h000, "neg_zero_e7");

    // Backpressure: result held while a second code is offered
    out_ready = 1'b0;
    accept(8'h23);
    wait_result(8'h23, 12'h00C, "bp_first");
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      in_fp = 8'h12; in_valid = 1'b1;
      check("bp_valid_held", int'(out_valid), 1);
      check("bp_dec_stable", int'(out_dec), 12'h00C);
      check("bp_in_ready_low", int'(in_ready), 0);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(8'h12, 12'h004, "bp_second");

    // Reset mid-SHIFT: clears asynchronously, aborted code never appears
    accept(8'h70);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_dec", int'(out_dec), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 check("no_pulse_after_rst", int'(out_valid), 0);
    end
    convert(8'h31, 12'h008, "after_rst");

    // Sweep a few more codes against the reference model
    for (int unsigned i = 0; i < 8; i++) begin
      logic [7:0] c;
      c = 8'(((i * 37) + 9) & 8'hFF);
      convert(c, ref_dec(c), "sweep");
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
